// File: rtl/decode_stage_pipelined_pkg.sv
// decode_stage_pipelined_pkg: shared instruction/control types, NOP control word and immediate extension
package decode_stage_pipelined_pkg;
  typedef logic [31:0] instruction_type;
  typedef enum logic [2:0] {ENC_NONE, ENC_R, ENC_I, ENC_S, ENC_B, ENC_U, ENC_J} encoding_type;
  typedef struct packed {
    encoding_type encoding;
    logic [3:0]   alu_op;
    logic         reg_write;
    logic         mem_read;
    logic         mem_write;
    logic         branch;
    logic         jump;
    logic         alu_src_imm;
  } control_type;
  localparam control_type NOP_CONTROL = '0;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  // Takes only bits [31:7] so indices match the ISA manual; returns a 32-bit sign-extended immediate.
  function automatic logic [31:0] immediate_extension(input logic [31:7] ib, input encoding_type enc);
    return enc == ENC_I ? {{20{ib[31]}}, ib[31:20]} :
           enc == ENC_S ? {{20{ib[31]}}, ib[31:25], ib[11:7]} :
           enc == ENC_B ? {{19{ib[31]}}, ib[31], ib[7], ib[30:25], ib[11:8], 1'b0} :
           enc == ENC_U ? {ib[31:12], 12'b0} :
           enc == ENC_J ? {{11{ib[31]}}, ib[31], ib[19:12], ib[20], ib[30:21], 1'b0} : 32'b0;
  endfunction
endpackage

// File: rtl/control_decoder.sv
// control_decoder: maps RV32I opcode/funct fields to a control word
//   opcode, funct3, funct7_5 : instruction fields
//   control                  : decoded control word, NOP_CONTROL for unknown opcodes
module control_decoder
  import decode_stage_pipelined_pkg::*;
(
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic        funct7_5,
  output control_type control
);
  always_comb begin
    control = NOP_CONTROL;
    case (opcode)
      OP_REG: begin
        control.encoding  = ENC_R;
        control.alu_op    = {funct7_5, funct3};
        control.reg_write = 1'b1;
      end
      OP_IMM: begin
        control.encoding    = ENC_I;
        control.alu_op      = {funct7_5 && funct3 == 3'b101, funct3};
        control.reg_write   = 1'b1;
        control.alu_src_imm = 1'b1;
      end
      OP_LOAD: begin
        control.encoding    = ENC_I;
        control.reg_write   = 1'b1;
        control.mem_read    = 1'b1;
        control.alu_src_imm = 1'b1;
      end
      OP_STORE: begin
        control.encoding    = ENC_S;
        control.mem_write   = 1'b1;
        control.alu_src_imm = 1'b1;
      end
      OP_BRANCH: begin
        control.encoding = ENC_B;
        control.alu_op   = {1'b0, funct3};
        control.branch   = 1'b1;
      end
      OP_JAL: begin
        control.encoding  = ENC_J;
        control.reg_write = 1'b1;
        control.jump      = 1'b1;
      end
      OP_JALR: begin
        control.encoding    = ENC_I;
        control.reg_write   = 1'b1;
        control.jump        = 1'b1;
        control.alu_src_imm = 1'b1;
      end
      OP_LUI, OP_AUIPC: begin
        control.encoding    = ENC_U;
        control.reg_write   = 1'b1;
        control.alu_src_imm = 1'b1;
      end
      default: control = NOP_CONTROL;
    endcase
  end
endmodule

// File: rtl/load_use_hazard_detector.sv
// load_use_hazard_detector: flags an incoming instruction that reads the destination of a load held in ID/EX
//   rs fields are compared regardless of instruction format (conservative)
module load_use_hazard_detector #(
  parameter int REG_ID_W = 5
) (
  input  logic                ex_valid,
  input  logic                ex_mem_read,
  input  logic [REG_ID_W-1:0] ex_rd_id,
  input  logic                in_valid,
  input  logic [REG_ID_W-1:0] rs1_id,
  input  logic [REG_ID_W-1:0] rs2_id,
  output logic                hazard
);
  assign hazard = ex_valid && ex_mem_read && ex_rd_id != '0 && in_valid &&
                  (rs1_id == ex_rd_id || rs2_id == ex_rd_id);
endmodule

// File: rtl/register_file.sv
// register_file: REG_COUNT x XLEN, two combinational reads, one synchronous write, x0 hardwired to 0
//   rs1_id/rs2_id -> rs1_data/rs2_data ; wb_en/wb_id/wb_data write port
//   DECODE_WB_BYPASS_EN: reads of the index being written this cycle return wb_data
module register_file #(
  parameter  int XLEN      = 32,
  parameter  int REG_COUNT = 32,
  localparam int REG_ID_W  = $clog2(REG_COUNT)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [REG_ID_W-1:0] rs1_id,
  input  logic [REG_ID_W-1:0] rs2_id,
  output logic [XLEN-1:0]     rs1_data,
  output logic [XLEN-1:0]     rs2_data,
  input  logic                wb_en,
  input  logic [REG_ID_W-1:0] wb_id,
  input  logic [XLEN-1:0]     wb_data
);
  logic [XLEN-1:0] regs [REG_COUNT];
  logic            wr;
  assign wr = wb_en && wb_id != '0;
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < REG_COUNT; i++) regs[i] <= '0;
    end else if (wr) begin
      regs[wb_id] <= wb_data;
    end
  end
`ifdef DECODE_WB_BYPASS_EN
  assign rs1_data = rs1_id == '0 ? '0 : wr && wb_id == rs1_id ? wb_data : regs[rs1_id];
  assign rs2_data = rs2_id == '0 ? '0 : wr && wb_id == rs2_id ? wb_data : regs[rs2_id];
`else
  assign rs1_data = rs1_id == '0 ? '0 : regs[rs1_id];
  assign rs2_data = rs2_id == '0 ? '0 : regs[rs2_id];
`endif
endmodule

// File: rtl/decode_stage_pipelined.sv
// decode_stage_pipelined: RV32I decode with register read, immediate extension and ID/EX register
//   fetch side  : in_valid/in_ready, in_instruction, in_pc, flush
//   write-back  : wb_en, wb_id, wb_data
//   execute side: out_valid/out_ready, out_pc, out_rs*_data, out_rs*_id, out_rd_id, out_imm, out_control
//   DECODE_WB_BYPASS_EN: same-cycle write-back forwarding inside the register file
module decode_stage_pipelined
  import decode_stage_pipelined_pkg::*;
#(
  parameter  int XLEN      = 32,
  parameter  int REG_COUNT = 32,
  localparam int REG_ID_W  = $clog2(REG_COUNT)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  instruction_type     in_instruction,
  input  logic [XLEN-1:0]     in_pc,
  input  logic                flush,
  input  logic                wb_en,
  input  logic [REG_ID_W-1:0] wb_id,
  input  logic [XLEN-1:0]     wb_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [XLEN-1:0]     out_pc,
  output logic [XLEN-1:0]     out_rs1_data,
  output logic [XLEN-1:0]     out_rs2_data,
  output logic [REG_ID_W-1:0] out_rs1_id,
  output logic [REG_ID_W-1:0] out_rs2_id,
  output logic [REG_ID_W-1:0] out_rd_id,
  output logic [XLEN-1:0]     out_imm,
  output control_type         out_control
);
  logic [REG_ID_W-1:0] rs1_id, rs2_id, rd_id;
  logic [XLEN-1:0]     rs1_data, rs2_data;
  logic [31:0]         imm;
  control_type         control;
  logic                hazard, advance;
  assign rs1_id   = REG_ID_W'(in_instruction[19:15]);
  assign rs2_id   = REG_ID_W'(in_instruction[24:20]);
  assign rd_id    = REG_ID_W'(in_instruction[11:7]);
  assign imm      = immediate_extension(in_instruction[31:7], control.encoding);
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance && !hazard && !reset;
  control_decoder u_control (
    .opcode   (in_instruction[6:0]),
    .funct3   (in_instruction[14:12]),
    .funct7_5 (in_instruction[30]),
    .control  (control)
  );
  register_file #(.XLEN(XLEN), .REG_COUNT(REG_COUNT)) u_regs (
    .clk      (clk),
    .reset    (reset),
    .rs1_id   (rs1_id),
    .rs2_id   (rs2_id),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .wb_en    (wb_en),
    .wb_id    (wb_id),
    .wb_data  (wb_data)
  );
  load_use_hazard_detector #(.REG_ID_W(REG_ID_W)) u_hazard (
    .ex_valid    (out_valid),
    .ex_mem_read (out_control.mem_read),
    .ex_rd_id    (out_rd_id),
    .in_valid    (in_valid),
    .rs1_id      (rs1_id),
    .rs2_id      (rs2_id),
    .hazard      (hazard)
  );
  // A hazard implies in_valid, so in_valid && !hazard is the accept condition once advancing.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid    <= 1'b0;
      out_pc       <= '0;
      out_rs1_data <= '0;
      out_rs2_data <= '0;
      out_rs1_id   <= '0;
      out_rs2_id   <= '0;
      out_rd_id    <= '0;
      out_imm      <= '0;
      out_control  <= NOP_CONTROL;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (advance) begin
      out_valid <= in_valid && !hazard;
      if (in_valid && !hazard) begin
        out_pc       <= in_pc;
        out_rs1_data <= rs1_data;
        out_rs2_data <= rs2_data;
        out_rs1_id   <= rs1_id;
        out_rs2_id   <= rs2_id;
        out_rd_id    <= rd_id;
        out_imm      <= XLEN'($signed(imm));
        out_control  <= control;
      end
    end
  end
endmodule
